// File: rtl/pcm_mic_rx_if.sv
// Parallel sample handshake between the microphone receiver (master) and capture logic (slave).
interface pcm_mic_rx_if #(
   parameter int WORD_BITS = 16
);
   logic [WORD_BITS-1:0] data_out;
   logic                 channel;
   logic                 valid;
   logic                 ready;

   modport master (output data_out, output channel, output valid, input ready);
   modport slave  (input data_out, input channel, input valid, output ready);
endinterface

// File: rtl/pcm_mic_rx.sv
// I2S microphone receiver: generates bclk/lrclk, deserialises MSB-first words with a one-bit delay.
// Optional macro PCM_RX_STEREO_EN captures both slots; default build captures the left slot only.
module pcm_mic_rx #(
   parameter int CLK_DIV   = 2,
   parameter int WORD_BITS = 16,
   parameter int SLOT_BITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         d_in,
   output logic         bclk,
   output logic         lrclk,
   output logic         overrun,
   pcm_mic_rx_if.master rx
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BITS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [DIV_W-1:0]     div_cnt;
   logic [CNT_W-1:0]     bit_cnt;
   logic [WORD_BITS-1:0] shift_reg;
   logic [WORD_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 word_done;
   logic                 slot_on;
   logic                 div_tc;
   logic                 rise;
   logic                 fall;
   logic                 in_word;

`ifdef PCM_RX_STEREO_EN
   logic done_ch;
   logic chan_q;
   assign slot_on    = 1'b1;
   assign rx.channel = chan_q;
`else
   assign slot_on    = ~lrclk;
   assign rx.channel = 1'b0;
`endif

   assign rx.data_out = data_q;
   assign rx.valid    = valid_q;

   always_comb begin
      div_tc  = (div_cnt == DIV_LAST);
      rise    = div_tc & ~bclk;
      fall    = div_tc & bclk;
      in_word = (bit_cnt != '0) && (bit_cnt <= WORD_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         bclk      <= 1'b0;
         lrclk     <= 1'b0;
         shift_reg <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun   <= 1'b0;
         word_done <= 1'b0;
`ifdef PCM_RX_STEREO_EN
         done_ch   <= 1'b0;
         chan_q    <= 1'b0;
`endif
      end else begin
         word_done <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            if (state == RUN) begin
               div_cnt   <= '0;
               bit_cnt   <= '0;
               bclk      <= 1'b0;
               lrclk     <= 1'b0;
               shift_reg <= '0;
            end
         end else begin
            state <= RUN;
            if (div_tc) begin
               div_cnt <= '0;
               bclk    <= ~bclk;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            // d_in is sampled on the same edge that registers bclk high
            if (rise && slot_on && in_word) begin
               shift_reg <= {shift_reg[WORD_BITS-2:0], d_in};
               if (bit_cnt == WORD_LAST) begin
                  word_done <= 1'b1;
`ifdef PCM_RX_STEREO_EN
                  done_ch   <= lrclk;
`endif
               end
            end
            if (fall) begin
               if (bit_cnt == SLOT_LAST) begin
                  bit_cnt <= '0;
                  lrclk   <= ~lrclk;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end

         // Completed word is loaded a cycle after its LSB, from the still-stable shift register
         if (word_done) begin
            if (valid_q && !rx.ready) begin
               overrun <= 1'b1;
            end else begin
               data_q  <= shift_reg;
               valid_q <= 1'b1;
`ifdef PCM_RX_STEREO_EN
               chan_q  <= done_ch;
`endif
            end
         end else if (valid_q && rx.ready) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pcm_mic_rx.sv
// Directed bench for pcm_mic_rx: cycle-timed microphone model and a word scoreboard.
module tb_pcm_mic_rx;

   localparam int CLK_DIV   = 2;
   localparam int WORD_BITS = 16;
   localparam int SLOT_BITS = 32;
   localparam int BPER      = 2 * CLK_DIV;
   localparam int RISE0     = CLK_DIV - 1;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic d_in;
   logic bclk;
   logic lrclk;
   logic overrun;

   pcm_mic_rx_if #(.WORD_BITS(WORD_BITS)) rx_if ();

   pcm_mic_rx #(
      .CLK_DIV  (CLK_DIV),
      .WORD_BITS(WORD_BITS),
      .SLOT_BITS(SLOT_BITS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .d_in   (d_in),
      .bclk   (bclk),
      .lrclk  (lrclk),
      .overrun(overrun),
      .rx     (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int en_cyc = -100;
   logic [15:0] wtab [0:7];
   logic [16:0] sb [$];
   logic [16:0] nw;
   int ld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives d_in for the coming edge from the bench's own slot timing, scoreboards accepted words
   task automatic tick();
      int e, n, b, k;
      logic [15:0] w;
      logic [16:0] exp;
      e = en_cyc + 1;
      d_in = 1'($urandom);
      if (e >= RISE0 && (e - RISE0) % BPER == 0) begin
         n = (e - RISE0) / BPER;
         b = n % SLOT_BITS;
         k = n / SLOT_BITS;
         if (b >= 1 && b <= WORD_BITS && k < 8) begin
            w = wtab[k];
            d_in = w[WORD_BITS - b];
         end
      end
      if (rx_if.valid === 1'b1 && rx_if.ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", {15'd0, rx_if.channel, rx_if.data_out}, 32'h1DEAD);
         end else begin
            exp = sb.pop_front();
            chk("sb_data", 32'(rx_if.data_out), 32'(exp[15:0]));
            chk("sb_channel", 32'(rx_if.channel), 32'(exp[16]));
         end
      end
      @(posedge clk);
      #1;
      en_cyc++;
   endtask

   task automatic run_to(input int c);
      while (en_cyc < c) tick();
   endtask

   initial begin
      reset = 1'b0;
      enable = 1'b1;
      d_in = 1'b0;
      rx_if.ready = 1'b0;
      for (int i = 0; i < 8; i++) wtab[i] = '0;

      repeat (3) tick();
      chk("rst_bclk", 32'(bclk), 0);
      chk("rst_lrclk", 32'(lrclk), 0);
      chk("rst_valid", 32'(rx_if.valid), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_data", 32'(rx_if.data_out), 0);
      chk("rst_channel", 32'(rx_if.channel), 0);

      // Left word, right slot, then overrun with ready low
      wtab[0] = 16'hA5C3; wtab[1] = 16'h1234; wtab[2] = 16'h0001;
      wtab[3] = 16'hCAFE; wtab[4] = 16'h0002; wtab[5] = 16'h7E57;
      sb.push_back({1'b0, 16'hA5C3});
`ifdef PCM_RX_STEREO_EN
      sb.push_back({1'b1, 16'h1234});
`endif
      rx_if.ready = 1'b1;
      reset = 1'b1;
      en_cyc = -1;
      run_to(1);
      chk("first_rise_bclk", 32'(bclk), 1);
      run_to(65);
      chk("pre_valid", 32'(rx_if.valid), 0);
      run_to(66);
      chk("left_valid", 32'(rx_if.valid), 1);
      chk("left_data", 32'(rx_if.data_out), 32'hA5C3);
      chk("left_channel", 32'(rx_if.channel), 0);
      run_to(67);
      chk("left_valid_drop", 32'(rx_if.valid), 0);
      run_to(126);
      chk("lrclk_left_end", 32'(lrclk), 0);
      run_to(127);
      chk("lrclk_right", 32'(lrclk), 1);
      run_to(194);
`ifdef PCM_RX_STEREO_EN
      chk("right_valid", 32'(rx_if.valid), 1);
      chk("right_data", 32'(rx_if.data_out), 32'h1234);
      chk("right_channel", 32'(rx_if.channel), 1);
`else
      chk("right_ignored", 32'(rx_if.valid), 0);
`endif
      run_to(195);
      rx_if.ready = 1'b0;
      sb.push_back({1'b0, 16'h0001});
      run_to(322);
      chk("ovr_first_valid", 32'(rx_if.valid), 1);
      chk("ovr_first_data", 32'(rx_if.data_out), 32'h0001);
      chk("ovr_none_yet", 32'(overrun), 0);
      run_to(578);
      chk("ovr_set", 32'(overrun), 1);
      chk("ovr_data_kept", 32'(rx_if.data_out), 32'h0001);
      chk("ovr_valid_kept", 32'(rx_if.valid), 1);
      run_to(579);
      rx_if.ready = 1'b1;
`ifdef PCM_RX_STEREO_EN
      sb.push_back({1'b1, 16'h7E57});
`endif
      tick();
      chk("ovr_valid_clear", 32'(rx_if.valid), 0);
      chk("ovr_sticky", 32'(overrun), 1);
      run_to(710);
      chk("sb_drained_b", 32'(sb.size()), 0);

      // Accept and load on the same edge
      reset = 1'b0;
      repeat (2) tick();
      chk("rst2_overrun", 32'(overrun), 0);
      for (int i = 0; i < 8; i++) wtab[i] = '0;
      wtab[0] = 16'hBEEF; wtab[1] = 16'h0F0F; wtab[2] = 16'hC001;
`ifdef PCM_RX_STEREO_EN
      ld = 194;
      nw = {1'b1, 16'h0F0F};
`else
      ld = 322;
      nw = {1'b0, 16'hC001};
`endif
      sb.push_back({1'b0, 16'hBEEF});
      sb.push_back(nw);
      rx_if.ready = 1'b0;
      reset = 1'b1;
      en_cyc = -1;
      run_to(66);
      chk("hold_data", 32'(rx_if.data_out), 32'hBEEF);
      run_to(ld - 1);
      chk("hold_valid", 32'(rx_if.valid), 1);
      chk("hold_data_late", 32'(rx_if.data_out), 32'hBEEF);
      rx_if.ready = 1'b1;
      tick();
      rx_if.ready = 1'b0;
      chk("simul_valid", 32'(rx_if.valid), 1);
      chk("simul_data", 32'(rx_if.data_out), 32'(nw[15:0]));
      chk("simul_channel", 32'(rx_if.channel), 32'(nw[16]));
      chk("simul_no_overrun", 32'(overrun), 0);
      rx_if.ready = 1'b1;
      tick();
      chk("simul_drain", 32'(rx_if.valid), 0);

      // Enable drop mid-word, then a clean word after re-enable
      reset = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 8; i++) wtab[i] = '0;
      wtab[0] = 16'h1357;
      reset = 1'b1;
      en_cyc = -1;
      run_to(34);
      chk("drop_bclk_high", 32'(bclk), 1);
      enable = 1'b0;
      tick();
      chk("drop_bclk", 32'(bclk), 0);
      chk("drop_lrclk", 32'(lrclk), 0);
      chk("drop_valid", 32'(rx_if.valid), 0);
      repeat (20) tick();
      chk("idle_valid", 32'(rx_if.valid), 0);
      chk("idle_bclk", 32'(bclk), 0);
      wtab[0] = 16'hFFFF;
      sb.push_back({1'b0, 16'hFFFF});
      enable = 1'b1;
      en_cyc = -1;
      run_to(66);
      chk("reen_valid", 32'(rx_if.valid), 1);
      chk("reen_data", 32'(rx_if.data_out), 32'hFFFF);
      run_to(67);
      chk("reen_drop", 32'(rx_if.valid), 0);
      chk("sb_drained_end", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
